// File: rtl/sram_1r1w.sv
// One-read/one-write synchronous RAM with a registered read port.
// Optionally forwards same-cycle write data to a read of the same address.
module sram_1r1w #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE         = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int WRITE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_enable
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_in_range, wr_in_range;

  // When the address space is exactly filled, every address is legal.
  generate
    if (SIZE >= (1 << ADDR_WIDTH)) begin : g_full
      assign rd_in_range = 1'b1;
      assign wr_in_range = 1'b1;
    end else begin : g_partial
      assign rd_in_range = (32'(rd_addr) < 32'(SIZE));
      assign wr_in_range = (32'(wr_addr) < 32'(SIZE));
    end
  endgenerate

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_enable) begin
      if (!rd_in_range) begin
        rd_data_d = '0;
      end else if ((WRITE_BYPASS != 0) && wr_enable && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[rd_addr];
      end
    end
  end

  // Array has no reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && wr_enable && wr_in_range) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sram_1r1w.sv
// Bench for sram_1r1w: three instances (bypass, no bypass, SIZE=20) share one
// stimulus stream and are checked every cycle against an array-based model.
module tb_sram_1r1w;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rd_addr = '0;
  logic       rd_enable = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic       wr_enable = 1'b0;
  logic [2:0] rd_b1, rd_b0, rd_s20;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_1r1w #(.DATA_WIDTH(3), .SIZE(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) u_b1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_b1),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable));
  sram_1r1w #(.DATA_WIDTH(3), .SIZE(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) u_b0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_b0),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable));
  sram_1r1w #(.DATA_WIDTH(3), .SIZE(20), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) u_s20 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_s20),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable));

  // Model: one 32-word array; instance 2 simply treats addresses >= 20 as absent.
  logic [2:0] mdl [32];
  bit         known [32];
  logic [2:0] exp_v [3];
  bit         exp_k [3] = '{0, 0, 0};

  function automatic int lim_of(input int k);
    return (k == 2) ? 20 : 32;
  endfunction

  function automatic logic [2:0] dut_of(input int k);
    return (k == 0) ? rd_b1 : (k == 1) ? rd_b0 : rd_s20;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        exp_v[k] <= 3'd0;
        exp_k[k] <= 1'b1;
      end
    end else begin
      if (rd_enable) begin
        for (int k = 0; k < 3; k++) begin
          if (int'(rd_addr) >= lim_of(k)) begin
            exp_v[k] <= 3'd0;
            exp_k[k] <= 1'b1;
          end else if (k != 1 && wr_enable && wr_addr == rd_addr) begin
            exp_v[k] <= wr_data;
            exp_k[k] <= 1'b1;
          end else begin
            exp_v[k] <= mdl[rd_addr];
            exp_k[k] <= known[rd_addr];
          end
        end
      end
      if (wr_enable) begin
        mdl[wr_addr]   <= wr_data;
        known[wr_addr] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (exp_k[k]) begin
        total++;
        if (dut_of(k) !== exp_v[k]) begin
          bad++;
          $display("FAIL cycle_cmp inst=%0d rd_data=%0d expected=%0d t=%0t",
                   k, dut_of(k), exp_v[k], $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, want, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", nm, got, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) known[i] = 1'b0;

    // Reset held with reads requested.
    rd_enable = 1'b1; rd_addr = 5'd3; wr_enable = 1'b1; wr_addr = 5'd3; wr_data = 3'd6;
    repeat (3) step();
    chk("reset_hold_b1", rd_b1, 3'd0);
    chk("reset_hold_s20", rd_s20, 3'd0);

    reset = 1'b1;
    rd_enable = 1'b0; wr_enable = 1'b1; wr_addr = 5'd4; wr_data = 3'b101;
    step();
    wr_enable = 1'b0; rd_enable = 1'b1; rd_addr = 5'd4;
    step();
    chk("wr_then_rd_b1", rd_b1, 3'b101);
    chk("wr_then_rd_b0", rd_b0, 3'b101);

    // Fill, then read back-to-back.
    rd_enable = 1'b0; wr_enable = 1'b1;
    for (int a = 0; a < 32; a++) begin
      wr_addr = 5'(a); wr_data = 3'(a % 8);
      step();
    end
    wr_enable = 1'b0; rd_enable = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      step();
      chk("seq_rd_b1", rd_b1, 3'(a % 8));
      chk("seq_rd_s20", rd_s20, (a < 20) ? 3'(a % 8) : 3'd0);
    end

    // Concurrent independent write/read (checked by the cycle compare).
    wr_enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rd_addr = 5'(k); wr_addr = 5'(31 - k); wr_data = 3'((k + 3) % 8);
      step();
    end

    // Same-address read/write collision.
    rd_enable = 1'b0; wr_addr = 5'd7; wr_data = 3'b010;
    step();
    rd_enable = 1'b1; rd_addr = 5'd7; wr_data = 3'b110;
    step();
    chk("bypass_on", rd_b1, 3'b110);
    chk("bypass_off", rd_b0, 3'b010);
    wr_enable = 1'b0;
    step();
    chk("after_bypass_off", rd_b0, 3'b110);

    // Read-enable hold.
    rd_enable = 1'b0; wr_enable = 1'b1; wr_addr = 5'd4; wr_data = 3'b101;
    step();
    wr_enable = 1'b0; rd_enable = 1'b1; rd_addr = 5'd4;
    step();
    rd_enable = 1'b0; rd_addr = 5'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_hold", rd_b1, 3'b101);
    end

    // Asynchronous reset between edges, plus a write lost to reset.
    wr_enable = 1'b1; wr_addr = 5'd10; wr_data = 3'b111;
    step();
    wr_enable = 1'b0; rd_enable = 1'b1; rd_addr = 5'd10;
    step();
    chk("pre_async_rst", rd_b1, 3'b111);
    reset = 1'b0;
    #1;
    chk("async_rst_b1", rd_b1, 3'd0);
    chk("async_rst_b0", rd_b0, 3'd0);
    wr_enable = 1'b1; wr_data = 3'b001;
    step();
    reset = 1'b1; wr_enable = 1'b0;
    step();
    chk("lost_write", rd_b1, 3'b111);

    // Out-of-range access on the 20-word instance.
    rd_enable = 1'b0; wr_enable = 1'b1; wr_addr = 5'd25; wr_data = 3'b111;
    step();
    wr_enable = 1'b0; rd_enable = 1'b1; rd_addr = 5'd25;
    step();
    chk("oor_rd_s20", rd_s20, 3'd0);
    chk("oor_rd_b1", rd_b1, 3'b111);
    for (int a = 0; a < 20; a++) begin
      rd_addr = 5'(a);
      step();
    end

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      rd_enable = $urandom_range(0, 3) != 0;
      wr_enable = $urandom_range(0, 1) != 0;
      rd_addr   = 5'($urandom_range(0, 31));
      wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      wr_data   = 3'($urandom_range(0, 7));
      step();
    end
    reset = 1'b1; rd_enable = 1'b0; wr_enable = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
